// File: rtl/lock_sequencer.sv
// lock_sequencer: canal lock transit controller.
// Equalizes the pound, opens each gate, and tracks boat entry/exit.
module lock_sequencer #(
    parameter int unsigned ARRIVAL_TICKS = 5,
    parameter int unsigned GATE_TICKS    = 3,
    parameter int unsigned TIMEOUT_TICKS = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       boat_req,
    input  logic       boat_entered,
    input  logic       boat_exited,
    input  logic [3:0] inside_lvl,
    input  logic [3:0] arriv_lvl,
    input  logic [3:0] dept_lvl,
    output logic       raise,
    output logic       lower,
    output logic       open_arriv,
    output logic       open_dept,
    output logic       five_min,
    output logic       boat_ack,
    output logic       busy,
    output logic [2:0] state
);

    localparam int unsigned MAX_AG = (ARRIVAL_TICKS > GATE_TICKS) ?
                                     ARRIVAL_TICKS : GATE_TICKS;
    localparam int unsigned MAX_T  = (MAX_AG > TIMEOUT_TICKS) ?
                                     MAX_AG : TIMEOUT_TICKS;
    localparam int unsigned CW     = $clog2(MAX_T + 2);

    localparam logic [CW-1:0] ARR_C   = CW'(ARRIVAL_TICKS);
    localparam logic [CW-1:0] GATE_C  = CW'(GATE_TICKS);
    localparam logic [CW-1:0] TMO_C   = CW'(TIMEOUT_TICKS);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREP_ARR  = 3'd1,
        OPEN_ARR  = 3'd2,
        SEAL_IN   = 3'd3,
        PREP_DEPT = 3'd4,
        OPEN_DEPT = 3'd5,
        SEAL_OUT  = 3'd6,
        FAULT     = 3'd7
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          seen;
    logic          seen_nxt;
    logic          arr_eq;
    logic          dep_eq;
    logic          open_st;
    logic          hit;

    assign arr_eq  = (inside_lvl == arriv_lvl);
    assign dep_eq  = (inside_lvl == dept_lvl);
    assign open_st = (cur == OPEN_ARR) || (cur == OPEN_DEPT);
    // A pulse on the gate-closing cycle still counts as seen.
    assign hit     = seen | ((cur == OPEN_ARR) ? boat_entered : boat_exited);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= IDLE;
            cnt  <= '0;
            seen <= 1'b0;
        end else begin
            cur  <= nxt;
            cnt  <= cnt_nxt;
            seen <= seen_nxt;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:      if (boat_req) nxt = PREP_ARR;
            PREP_ARR: begin
                if (!boat_req)                  nxt = IDLE;
                else if (cnt == '0 && arr_eq)   nxt = OPEN_ARR;
            end
            OPEN_ARR: begin
                if (!arr_eq)                    nxt = FAULT;
                else if (hit && cnt >= GATE_C)  nxt = SEAL_IN;
                else if (!hit && cnt >= TMO_C)  nxt = IDLE;
            end
            SEAL_IN:   nxt = PREP_DEPT;
            PREP_DEPT: if (dep_eq) nxt = OPEN_DEPT;
            OPEN_DEPT: begin
                if (!dep_eq)                    nxt = FAULT;
                else if (hit && cnt >= GATE_C)  nxt = SEAL_OUT;
            end
            SEAL_OUT:  nxt = IDLE;
            FAULT:     nxt = FAULT;
            default:   nxt = IDLE;
        endcase

        // Shared counter: countdown in PREP_ARR, dwell in the OPEN states.
        cnt_nxt = '0;
        if (nxt == PREP_ARR) begin
            if (cur != PREP_ARR)   cnt_nxt = ARR_C;
            else if (cnt != '0)    cnt_nxt = cnt - 1'b1;
        end else if (nxt == OPEN_ARR || nxt == OPEN_DEPT) begin
            if (cur != nxt)        cnt_nxt = CW'(1);
            else if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
            else                   cnt_nxt = cnt;
        end

        seen_nxt = (open_st && cur == nxt) ? hit : 1'b0;
    end

    always_comb begin
        raise      = 1'b0;
        lower      = 1'b0;
        open_arriv = 1'b0;
        open_dept  = 1'b0;
        five_min   = 1'b0;
        boat_ack   = 1'b0;
        case (cur)
            PREP_ARR: begin
                five_min = 1'b1;
                raise    = (inside_lvl < arriv_lvl);
                lower    = (inside_lvl > arriv_lvl);
            end
            PREP_DEPT: begin
                raise = (inside_lvl < dept_lvl);
                lower = (inside_lvl > dept_lvl);
            end
            OPEN_ARR:  open_arriv = 1'b1;
            OPEN_DEPT: open_dept  = 1'b1;
            SEAL_OUT:  boat_ack   = 1'b1;
            default: ;
        endcase
    end

    assign busy  = (cur != IDLE);
    assign state = cur;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: scenario bench with a per-cycle expected-output queue.
// A simple water model steps inside_lvl on raise/lower.
module tb_lock_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PA   = 3'd1;
    localparam logic [2:0] S_OA   = 3'd2;
    localparam logic [2:0] S_SI   = 3'd3;
    localparam logic [2:0] S_PD   = 3'd4;
    localparam logic [2:0] S_OD   = 3'd5;
    localparam logic [2:0] S_SO   = 3'd6;
    localparam logic [2:0] S_FLT  = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       boat_req;
    logic       boat_entered;
    logic       boat_exited;
    logic [3:0] inside_lvl;
    logic [3:0] arriv_lvl;
    logic [3:0] dept_lvl;
    logic       raise;
    logic       lower;
    logic       open_arriv;
    logic       open_dept;
    logic       five_min;
    logic       boat_ack;
    logic       busy;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t sbq[$];

    lock_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .boat_req     (boat_req),
        .boat_entered (boat_entered),
        .boat_exited  (boat_exited),
        .inside_lvl   (inside_lvl),
        .arriv_lvl    (arriv_lvl),
        .dept_lvl     (dept_lvl),
        .raise        (raise),
        .lower        (lower),
        .open_arriv   (open_arriv),
        .open_dept    (open_dept),
        .five_min     (five_min),
        .boat_ack     (boat_ack),
        .busy         (busy),
        .state        (state)
    );

    always #5 clk = ~clk;

    // {state, busy, raise, lower, open_arriv, open_dept, five_min, boat_ack}
    function automatic logic [9:0] obs();
        return {state, busy, raise, lower,
                open_arriv, open_dept, five_min, boat_ack};
    endfunction

    // o = {raise, lower, open_arriv, open_dept, five_min, boat_ack}
    task automatic push(string tag, logic [2:0] st, int n, logic [5:0] o);
        exp_t e;
        e.tag = tag;
        e.v   = {st, (st != S_IDLE), o};
        repeat (n) sbq.push_back(e);
    endtask

    task automatic tick(logic [1:0] rl);
        @(posedge clk);
        #1;
        if (rl[1]) inside_lvl = inside_lvl + 4'd1;
        if (rl[0]) inside_lvl = inside_lvl - 4'd1;
        boat_entered = 1'b0;
        boat_exited  = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [1:0] rl;
        int n;
        reset = 1'b1;
        boat_req = 1'b1;
        boat_entered = 1'b0;
        boat_exited = 1'b0;
        inside_lvl = 4'd3;
        arriv_lvl = 4'd5;
        dept_lvl = 4'd1;
        @(posedge clk);
        #1;
        push("reset", S_IDLE, 3, 6'b000000);
        n = sbq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs() !== e.v) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got %b exp %b", e.tag, i, obs(), e.v);
            end
            rl = {raise, lower};
            reset = (i == 0);
            boat_req = (i == 0);
            tick(rl);
        end
    endtask

    task automatic test_full_transit();
        exp_t e;
        logic [1:0] rl;
        int n;
        inside_lvl = 4'd3;
        arriv_lvl = 4'd5;
        dept_lvl = 4'd1;
        push("ft_idle",   S_IDLE, 1, 6'b000000);
        push("ft_raise",  S_PA,   2, 6'b100010);
        push("ft_wait",   S_PA,   4, 6'b000010);
        push("ft_oa",     S_OA,   3, 6'b001000);
        push("ft_seal",   S_SI,   1, 6'b000000);
        push("ft_lower",  S_PD,   4, 6'b010000);
        push("ft_pd_eq",  S_PD,   1, 6'b000000);
        push("ft_od",     S_OD,   3, 6'b000100);
        push("ft_ack",    S_SO,   1, 6'b000001);
        push("ft_done",   S_IDLE, 1, 6'b000000);
        n = sbq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs() !== e.v) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got %b exp %b", e.tag, i, obs(), e.v);
            end
            rl = {raise, lower};
            boat_req = (i < 17);
            boat_entered = (i == 7) || (i == 12);
            boat_exited = (i == 8) || (i == 16);
            tick(rl);
        end
    endtask

    task automatic test_timeout(bit win);
        exp_t e;
        logic [1:0] rl;
        int n;
        inside_lvl = 4'd2;
        arriv_lvl = 4'd2;
        dept_lvl = 4'd2;
        push("to_idle", S_IDLE, 1, 6'b000000);
        push("to_pa",   S_PA,   6, 6'b000010);
        push("to_oa",   S_OA,  15, 6'b001000);
        if (win) begin
            push("tw_seal", S_SI,   1, 6'b000000);
            push("tw_pd",   S_PD,   1, 6'b000000);
            push("tw_od",   S_OD,   3, 6'b000100);
            push("tw_ack",  S_SO,   1, 6'b000001);
            push("tw_done", S_IDLE, 1, 6'b000000);
        end else begin
            push("to_abort", S_IDLE, 2, 6'b000000);
        end
        n = sbq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs() !== e.v) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got %b exp %b", e.tag, i, obs(), e.v);
            end
            rl = {raise, lower};
            boat_req = (i < 8);
            boat_entered = win && (i == 21);
            boat_exited = win && (i == 24);
            tick(rl);
        end
    endtask

    task automatic test_target_fault();
        exp_t e;
        logic [1:0] rl;
        int n;
        inside_lvl = 4'd4;
        arriv_lvl = 4'd5;
        dept_lvl = 4'd4;
        push("tf_idle",  S_IDLE, 1, 6'b000000);
        push("tf_raise", S_PA,   1, 6'b100010);
        push("tf_lower", S_PA,   3, 6'b010010);
        push("tf_wait",  S_PA,   2, 6'b000010);
        push("tf_oa",    S_OA,   3, 6'b001000);
        push("tf_seal",  S_SI,   1, 6'b000000);
        push("tf_pd_up", S_PD,   2, 6'b100000);
        push("tf_pd_eq", S_PD,   1, 6'b000000);
        push("tf_od",    S_OD,   1, 6'b000100);
        push("tf_fault", S_FLT,  5, 6'b000000);
        push("tf_reset", S_IDLE, 2, 6'b000000);
        n = sbq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs() !== e.v) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got %b exp %b", e.tag, i, obs(), e.v);
            end
            rl = {raise, lower};
            if (i == 1) arriv_lvl = 4'd2;
            if (i == 14) inside_lvl = 4'd5;
            boat_req = (i < 20);
            boat_entered = (i == 7);
            boat_exited = (i == 16) || (i == 17);
            reset = (i == 19);
            tick(rl);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [1:0] rl;
        int n;
        inside_lvl = 4'd5;
        arriv_lvl = 4'd5;
        dept_lvl = 4'd1;
        push("rm_idle",  S_IDLE, 1, 6'b000000);
        push("rm_pa",    S_PA,   6, 6'b000010);
        push("rm_oa",    S_OA,   3, 6'b001000);
        push("rm_seal",  S_SI,   1, 6'b000000);
        push("rm_lower", S_PD,   2, 6'b010000);
        push("rm_reset", S_IDLE, 1, 6'b000000);
        push("rm_pa2",   S_PA,   1, 6'b100010);
        push("rm_drop",  S_IDLE, 2, 6'b000000);
        n = sbq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs() !== e.v) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got %b exp %b", e.tag, i, obs(), e.v);
            end
            rl = {raise, lower};
            boat_req = (i < 14);
            boat_entered = (i == 7);
            reset = (i == 12);
            tick(rl);
        end
    endtask

    initial begin
        test_reset();
        test_full_transit();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_target_fault();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
